uart_frame_sender: RTL and testbench
====================================

// Module: uart_frame_sender
// PURPOSE
//  Sequencer that streams a processed image frame out of the frame buffer through Uart_tx.
//  On a start pulse it reads FRAME_BYTES bytes, one per address, from a synchronous-read memory port.
//  It hands each byte to Uart_tx with a one-cycle i_Tx_DV pulse, waits for o_Tx_Done, then advances.
//  It sits between the edge-detector frame buffer and the single Uart_tx instance, and is that transmitter's only driver.
// PARAMETERS
//  FRAME_BYTES  19200  bytes per frame (160x120 pixels, 8 bit); legal range 1..2**ADDR_WIDTH
//  ADDR_WIDTH   15     frame buffer address width
// PORTS
//  i_Clock      in   1           system clock, rising edge
//  i_Reset      in   1           asynchronous, active-high reset
//  i_Start      in   1           single-cycle pulse: send one frame
//  i_Abort      in   1           level/pulse: stop at next byte boundary
//  o_Busy       out  1           high from the cycle after accepted start until return to IDLE
//  o_Done       out  1           single-cycle pulse: frame (and checksum) fully transmitted
//  o_Rd_En      out  1           frame buffer read enable
//  o_Rd_Addr    out  ADDR_WIDTH  frame buffer read address
//  i_Rd_Data    in   8           read data, valid exactly 1 cycle after o_Rd_En
//  o_Tx_DV      out  1           to Uart_tx i_Tx_DV
//  o_Tx_Byte    out  8           to Uart_tx i_Tx_Byte, held stable from DV until i_Tx_Done
//  i_Tx_Active  in   1           from Uart_tx o_Tx_Active
//  i_Tx_Done    in   1           from Uart_tx o_Tx_Done (1-cycle pulse)
// BEHAVIOUR
//  Reset (async): state=IDLE; o_Busy, o_Done, o_Rd_En, o_Tx_DV = 0; o_Rd_Addr, o_Tx_Byte, byte counter, checksum = 0.
//   Takes effect immediately, including mid-byte; the partial serial byte is Uart_tx's concern.
//  FSM states: IDLE, FETCH, LOAD, SEND, WAIT_DONE, NEXT, CKSUM, CKSUM_WAIT, FINISH.
//  IDLE: i_Start=1 -> FETCH; addr <= 0, checksum <= 0.
//   i_Start while not IDLE is ignored (no queuing).
//  FETCH: o_Rd_En=1 for 1 cycle with o_Rd_Addr=addr -> LOAD.
//  LOAD: o_Tx_Byte <= i_Rd_Data; checksum <= checksum + i_Rd_Data (mod 256) -> SEND.
//  SEND: if i_Tx_Active=0, pulse o_Tx_DV for exactly 1 cycle -> WAIT_DONE.
//   If i_Tx_Active=1, hold in SEND with DV low.
//  WAIT_DONE: wait for i_Tx_Done=1 -> NEXT. No timeout.
//  NEXT: abort pending -> IDLE (no o_Done).
//   Else if addr==FRAME_BYTES-1 -> CKSUM (macro on) or FINISH (macro off).
//   Else addr <= addr+1 -> FETCH.
//  Latency: start pulse at cycle N -> o_Rd_En at N+1 -> o_Tx_DV at N+3 (if Tx idle).
//   Next byte's DV comes 4 cycles after i_Tx_Done.
//  Address never wraps: the last address issued is FRAME_BYTES-1; addr returns to 0 only on a new start.
//  Abort: sampled any cycle while busy into a sticky flag, cleared in IDLE.
//   The byte in flight always completes; the flag is acted on in NEXT or before CKSUM.
//   Abort in the same cycle as start in IDLE: the start wins, the abort is ignored.
//  FINISH: o_Done=1 for 1 cycle -> IDLE. o_Busy deasserts in the same cycle IDLE is re-entered.
//  FRAME_BYTES=1: FETCH/LOAD/SEND once, then straight to end-of-frame handling.
// CONFIGURATION
//  UART_FRAME_CHECKSUM_EN defined:
//   After the last pixel, CKSUM loads o_Tx_Byte=checksum and goes to SEND-equivalent DV handling.
//   CKSUM_WAIT waits for i_Tx_Done, then -> FINISH.
//   Checksum = 8-bit modulo-256 sum of all frame bytes.
//  UART_FRAME_CHECKSUM_EN undefined:
//   No checksum logic or register; NEXT goes directly to FINISH.
//   Exactly FRAME_BYTES DV pulses per frame.
// TESTING (bench: FRAME_BYTES=4, memory model 1-cycle read, real Uart_tx)
//  1. Mem={10,20,30,40}h, start -> Rd_Addr 0,1,2,3 in order; serial bytes 10,20,30,40.
//     Then (checksum on) one extra byte A0; o_Done one pulse; 4 or 5 DV pulses total.
//  2. Start pulse with 3 cycles of DV latency measured -> o_Rd_En at N+1, o_Tx_DV at N+3.
//     o_Tx_Byte stable until i_Tx_Done.
//  3. Second start during byte 2 -> ignored; exactly one frame sent; one o_Done.
//  4. Abort pulse during byte 1 -> byte 1 completes on the serial line.
//     No further o_Rd_En; IDLE; o_Done never pulses; next start sends from addr 0.
//  5. Reset asserted mid-byte 3 -> o_Tx_DV, o_Rd_En, o_Busy = 0 the same cycle.
//     After release, a start sends the full frame from 0.
//  6. Mem={FF,FF,03,00}h, checksum on -> checksum byte 01 (wrap mod 256).
//     Also force i_Tx_Active=1 at SEND -> DV is withheld until Active drops.

Source files
------------

// File: rtl/uart_frame_sender_if.sv
// Frame-sender bundle: start/abort control, status, frame-buffer read port and Uart_tx handshake.
// master = sequencer side, slave = environment (memory, transmitter, controller).
interface uart_frame_sender_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic                  tx_dv;
    logic [7:0]            tx_byte;
    logic                  tx_active;
    logic                  tx_done;

    modport master (
        input  start, abort, rd_data, tx_active, tx_done,
        output busy, done, rd_en, rd_addr, tx_dv, tx_byte
    );

    modport slave (
        output start, abort, rd_data, tx_active, tx_done,
        input  busy, done, rd_en, rd_addr, tx_dv, tx_byte
    );
endinterface

// File: rtl/uart_frame_sender.sv
// Streams FRAME_BYTES frame-buffer bytes through one Uart_tx; UART_FRAME_CHECKSUM_EN appends a mod-256 sum byte.
// Start -> rd_en +1 cycle, tx_dv +3; next byte 4 cycles after tx_done; tx_dv is withheld while tx_active is high.
module uart_frame_sender #(
    parameter int FRAME_BYTES = 19200,
    parameter int ADDR_WIDTH  = 15
) (
    input logic                 clk,
    input logic                 rst,
    uart_frame_sender_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, SEND, WAIT_DONE, NEXT, CKSUM, CKSUM_WAIT, FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            tx_byte_q;
    logic                  abort_q;
    logic                  abort_now;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]            checksum_q;
`endif

    // An abort arriving in NEXT itself is honoured without waiting for the flag.
    assign abort_now = abort_q | bus.abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.start) state_d = FETCH;
            FETCH:     state_d = LOAD;
            LOAD:      state_d = SEND;
            SEND:      if (!bus.tx_active) state_d = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done) state_d = NEXT;
            NEXT: begin
                if (abort_now) begin
                    state_d = IDLE;
                end else if (addr_q == LAST_ADDR) begin
`ifdef UART_FRAME_CHECKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = FINISH;
`endif
                end else begin
                    state_d = FETCH;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            CKSUM:      if (!bus.tx_active) state_d = CKSUM_WAIT;
            CKSUM_WAIT: if (bus.tx_done) state_d = FINISH;
`endif
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            tx_byte_q  <= '0;
            abort_q    <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            abort_q <= (state_q == IDLE) ? 1'b0 : (abort_q | bus.abort);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                    end
                end
                LOAD: begin
                    tx_byte_q  <= bus.rd_data;
`ifdef UART_FRAME_CHECKSUM_EN
                    checksum_q <= checksum_q + bus.rd_data;
`endif
                end
                NEXT: begin
                    if (state_d == FETCH) addr_q <= addr_q + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    // The last pixel's done has already fired, so the byte may change here.
                    if (state_d == CKSUM) tx_byte_q <= checksum_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == FINISH);
    assign bus.rd_en   = (state_q == FETCH);
    assign bus.rd_addr = addr_q;
    assign bus.tx_byte = tx_byte_q;
    assign bus.tx_dv   = ((state_q == SEND) || (state_q == CKSUM)) && !bus.tx_active;
endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed + randomized bench: 1-cycle memory model, behavioural Uart_tx model, queue-based frame reference.
module tb_uart_frame_sender;
    localparam int FB      = 4;
    localparam int AW      = 3;
    localparam int TX_CYC  = 5;
    localparam int LIMIT   = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_active;
    logic uart_active;
    logic [7:0] cur_byte;
    int unsigned uart_cnt;
    logic [7:0] mem [0:7];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_n, rd_cyc, dv_cyc, last_txdone_cyc;
    int txdone_cnt, done_cnt, stab_err, gap_err;
    logic [7:0]    dv_log[$];
    logic [AW-1:0] addr_log[$];

    uart_frame_sender_if #(.ADDR_WIDTH(AW)) bus ();

    uart_frame_sender #(.FRAME_BYTES(FB), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    assign bus.tx_active = uart_active | hold_active;

    // Transmitter: busy TX_CYC+1 cycles per byte, then a one-cycle done pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_active <= 1'b0;
            bus.tx_done <= 1'b0;
            uart_cnt    <= 0;
            cur_byte    <= 8'h00;
        end else begin
            bus.tx_done <= 1'b0;
            if (uart_active) begin
                if (uart_cnt == 0) begin
                    uart_active <= 1'b0;
                    bus.tx_done <= 1'b1;
                end else begin
                    uart_cnt <= uart_cnt - 1;
                end
            end else if (bus.tx_dv) begin
                uart_active <= 1'b1;
                uart_cnt    <= TX_CYC;
                cur_byte    <= bus.tx_byte;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.rd_en) begin
            addr_log.push_back(bus.rd_addr);
            if (rd_cyc < 0) rd_cyc = cyc;
        end
        if (bus.tx_dv) begin
            dv_log.push_back(bus.tx_byte);
            if (dv_cyc < 0) dv_cyc = cyc;
            else if (dv_log.size() <= FB && (cyc - last_txdone_cyc) != 4) gap_err++;
        end
        if (bus.tx_done) begin
            txdone_cnt++;
            last_txdone_cyc = cyc;
        end
        if (bus.done) done_cnt++;
        if (uart_active && bus.tx_byte !== cur_byte) stab_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        dv_log.delete();
        addr_log.delete();
        rd_cyc = -1; dv_cyc = -1; last_txdone_cyc = 0;
        txdone_cnt = 0; done_cnt = 0; stab_err = 0; gap_err = 0;
    endtask

    task automatic start_frame();
        clear_logs();
        @(posedge clk); #1;
        bus.start = 1'b1;
        start_n = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy && k < LIMIT) begin @(posedge clk); #1; k++; end
        check({tag, " idle timeout"}, 32'(k < LIMIT), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_dv(input int n, input string tag);
        int k = 0;
        while (dv_log.size() < n && k < LIMIT) begin @(posedge clk); #1; k++; end
        check({tag, " dv timeout"}, 32'(k < LIMIT), 1);
    endtask

    // Reference: bytes in address order, then the mod-256 sum when the checksum build is on.
    task automatic check_frame(input string tag);
        logic [7:0] exp[$];
        int sum = 0;
        for (int i = 0; i < FB; i++) begin
            exp.push_back(mem[i]);
            sum += mem[i];
        end
`ifdef UART_FRAME_CHECKSUM_EN
        exp.push_back(8'(sum % 256));
`endif
        check({tag, " dv count"}, dv_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < dv_log.size()) check($sformatf("%s byte%0d", tag, i), dv_log[i], exp[i]);
        check({tag, " rd count"}, addr_log.size(), FB);
        for (int i = 0; i < FB; i++)
            if (i < addr_log.size()) check($sformatf("%s addr%0d", tag, i), addr_log[i], i);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " tx done count"}, txdone_cnt, exp.size());
        check({tag, " byte stable"}, stab_err, 0);
        check({tag, " dv gap"}, gap_err, 0);
        check({tag, " busy low"}, bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        hold_active = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        clear_logs();

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst rd_en", bus.rd_en, 0);
        check("rst tx_dv", bus.tx_dv, 0);
        check("rst rd_addr", bus.rd_addr, 0);
        check("rst tx_byte", bus.tx_byte, 0);
        rst = 1'b0;

        // Basic frame and start-to-output latency.
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
        start_frame();
        wait_idle("t1");
        check_frame("t1");
        check("t2 rd latency", rd_cyc - start_n, 1);
        check("t2 dv latency", dv_cyc - start_n, 3);

        // Second start while busy is ignored.
        start_frame();
        wait_dv(2, "t3");
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("t3");
        check_frame("t3");

        // Abort during byte 1: byte completes, nothing further.
        start_frame();
        wait_dv(1, "t4");
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        wait_idle("t4");
        repeat (20) @(posedge clk);
        #1;
        check("t4 dv count", dv_log.size(), 1);
        check("t4 byte0", dv_log[0], mem[0]);
        check("t4 tx done", txdone_cnt, 1);
        check("t4 rd count", addr_log.size(), 1);
        check("t4 no done", done_cnt, 0);
        check("t4 busy", bus.busy, 0);
        for (int i = 0; i < FB; i++) mem[i] = 8'($urandom_range(0, 255));
        start_frame();
        wait_idle("t4b");
        check_frame("t4b");

        // Reset mid byte 3.
        start_frame();
        wait_dv(3, "t5");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5 tx_dv", bus.tx_dv, 0);
        check("t5 rd_en", bus.rd_en, 0);
        check("t5 busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_frame();
        wait_idle("t5b");
        check_frame("t5b");

        // Checksum wrap and DV withheld while the transmitter reports active.
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h03; mem[3] = 8'h00;
        hold_active = 1'b1;
        start_frame();
        repeat (8) @(posedge clk);
        #1;
        check("t6 dv withheld", dv_log.size(), 0);
        check("t6 busy held", bus.busy, 1);
        hold_active = 1'b0;
        wait_idle("t6");
        check_frame("t6");

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FB; i++) mem[i] = 8'($urandom_range(0, 255));
            start_frame();
            wait_idle($sformatf("rnd%0d", f));
            check_frame($sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
